// File: rtl/bitty_pkg.sv
// Shared constants for the Bitty control unit: state codes, operand mux
// selects, instruction formats and instruction field positions.
package bitty_pkg;

    // Sequencer states, binary encoded.
    typedef logic [2:0] state_t;
    localparam state_t StIdle  = 3'd0;
    localparam state_t StLoadS = 3'd1;
    localparam state_t StLoadC = 3'd2;
    localparam state_t StExec  = 3'd3;
    localparam state_t StWrite = 3'd4;
    localparam state_t StNop   = 3'd5;

    // Operand mux selects beyond the register range 0..7.
    localparam logic [3:0] MUX_IMM  = 4'h8;
    localparam logic [3:0] MUX_RES  = 4'h9;
    localparam logic [3:0] MUX_NONE = 4'hF;

    // Instruction formats held in IR[1:0]; any format with bit 1 set is a NOP.
    localparam logic [1:0] FMT_RR  = 2'b00;
    localparam logic [1:0] FMT_IMM = 2'b01;

    // Instruction field positions.
    localparam int unsigned RX_MSB  = 15;
    localparam int unsigned RX_LSB  = 13;
    localparam int unsigned RY_MSB  = 12;
    localparam int unsigned RY_LSB  = 10;
    localparam int unsigned IMM_MSB = 12;
    localparam int unsigned IMM_LSB = 5;
    localparam int unsigned ALU_MSB = 4;
    localparam int unsigned ALU_LSB = 2;
    localparam int unsigned FMT_MSB = 1;
    localparam int unsigned FMT_LSB = 0;

    // Formats other than reg-reg and immediate execute as a NOP.
    function automatic logic fmt_is_illegal(input logic [1:0] fmt);
        return fmt[1];
    endfunction

endpackage

// File: rtl/bitty_decoder.sv
// Combinational field extraction from the latched instruction register.
module bitty_decoder
    import bitty_pkg::*;
(
    input  logic [15:0] ir_i,
    output logic [2:0]  rx_o,
    output logic [2:0]  ry_o,
    output logic [7:0]  imm8_o,
    output logic [2:0]  alu_sel_o,
    output logic [1:0]  fmt_o,
    output logic        illegal_o
);

    assign rx_o      = ir_i[RX_MSB:RX_LSB];
    assign ry_o      = ir_i[RY_MSB:RY_LSB];
    assign imm8_o    = ir_i[IMM_MSB:IMM_LSB];
    assign alu_sel_o = ir_i[ALU_MSB:ALU_LSB];
    assign fmt_o     = ir_i[FMT_MSB:FMT_LSB];
    assign illegal_o = fmt_is_illegal(ir_i[FMT_MSB:FMT_LSB]);

endmodule

// File: rtl/bitty_control_unit.sv
// Bitty sequencer: latches one instruction per accepted run request and steps
// the operand mux, operand/result latch enables, ALU select and register write
// enable through LOAD_S, LOAD_C, EXEC and WRITE, pulsing done in WRITE.
// Outputs depend only on state and IR, never directly on run/instruction.
module bitty_control_unit
    import bitty_pkg::*;
#(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned NREG   = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              run,
    input  logic [15:0]       instruction,
    output logic [3:0]        mux_sel,
    output logic [DATA_W-1:0] im_d,
    output logic              en_s,
    output logic              en_c,
    output logic              en_i,
    output logic [2:0]        alu_sel,
    output logic [NREG-1:0]   en_reg,
    output logic              busy,
    output logic              done
);

    state_t      state_q, state_d;
    logic [15:0] ir_q, ir_d;
    logic [2:0]  alu_sel_q, alu_sel_d;

    logic [2:0]  dec_rx;
    logic [2:0]  dec_ry;
    logic [7:0]  dec_imm8;
    logic [2:0]  dec_alu;
    logic [1:0]  dec_fmt;
    logic        dec_illegal;

    bitty_decoder u_decoder (
        .ir_i      (ir_q),
        .rx_o      (dec_rx),
        .ry_o      (dec_ry),
        .imm8_o    (dec_imm8),
        .alu_sel_o (dec_alu),
        .fmt_o     (dec_fmt),
        .illegal_o (dec_illegal)
    );

    // The NOP branch is chosen at accept from the raw instruction, so the
    // latched illegal flag is informational only.
    logic unused_dec_illegal;
    assign unused_dec_illegal = dec_illegal;

    // Next-state logic: accept in IDLE, otherwise walk the fixed sequence.
    always_comb begin
        state_d   = state_q;
        ir_d      = ir_q;
        alu_sel_d = alu_sel_q;
        case (state_q)
            StIdle: begin
                if (run) begin
                    ir_d    = instruction;
                    state_d = fmt_is_illegal(instruction[FMT_MSB:FMT_LSB]) ? StNop : StLoadS;
                end
            end
            StLoadS: state_d = StLoadC;
            StLoadC: begin
                state_d   = StExec;
                // alu_sel becomes visible in EXEC and holds until the next EXEC.
                alu_sel_d = dec_alu;
            end
            StExec:  state_d = StWrite;
            StWrite: state_d = StIdle;
            StNop:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // State, IR and ALU select registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= StIdle;
            ir_q      <= '0;
            alu_sel_q <= '0;
        end else begin
            state_q   <= state_d;
            ir_q      <= ir_d;
            alu_sel_q <= alu_sel_d;
        end
    end

    // Output decode from state and latched IR.
    always_comb begin
        mux_sel = MUX_NONE;
        en_s    = 1'b0;
        en_c    = 1'b0;
        en_i    = 1'b0;
        en_reg  = '0;
        done    = 1'b0;
        case (state_q)
            StLoadS: begin
                mux_sel = {1'b0, dec_rx};
                en_s    = 1'b1;
            end
            StLoadC: begin
                mux_sel = (dec_fmt == FMT_RR) ? {1'b0, dec_ry} : MUX_IMM;
                en_c    = 1'b1;
            end
            StExec: begin
                en_i = 1'b1;
            end
            StWrite: begin
                mux_sel        = MUX_RES;
                en_reg[dec_rx] = 1'b1;
                done           = 1'b1;
            end
            StNop: begin
                done = 1'b1;
            end
            default: begin
                mux_sel = MUX_NONE;
            end
        endcase
    end

    assign busy    = (state_q != StIdle);
    assign im_d    = DATA_W'(dec_imm8);
    assign alu_sel = alu_sel_q;

endmodule
